// File: rtl/ram_controller.sv
// Valid/ready front end for a single-port synchronous RAM: single writes, single or burst reads.
// Optional performance counters are compiled in with `define RAM_CTRL_PERF_CNT_EN.
module ram_controller #(
    parameter int ADDRESS_SIZE  = 11,
    parameter int MEM_WORD_SIZE = 64,
    parameter int BURST_LEN     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic                     req_burst,
    input  logic [ADDRESS_SIZE-1:0]  req_addr,
    input  logic [MEM_WORD_SIZE-1:0] req_wdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic                     resp_write,
    output logic                     resp_last,
    output logic [MEM_WORD_SIZE-1:0] resp_rdata,
    output logic [ADDRESS_SIZE-1:0]  ram_address,
    output logic                     ram_is_reading,
`ifdef RAM_CTRL_PERF_CNT_EN
    output logic [31:0]              perf_rd_beats,
    output logic [31:0]              perf_wr_count,
`endif
    inout  wire  [MEM_WORD_SIZE-1:0] ram_data
);

    localparam int BW = $clog2(BURST_LEN);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    typedef enum logic [2:0] {IDLE, WR, RD, RD_CAP, RESP} state_t;

    state_t                   state, state_next;
    logic [ADDRESS_SIZE-1:0]  addr;
    logic [MEM_WORD_SIZE-1:0] wdata;
    logic                     is_write;
    logic                     burst;
    logic [BW-1:0]            beat;
    logic                     more_beats;
    logic                     accept;
    logic                     handshake;

    assign accept     = (state == IDLE) && req_valid;
    assign handshake  = (state == RESP) && resp_ready;
    assign more_beats = !is_write && burst && (beat != LAST_BEAT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = req_write ? WR : RD;
            WR:      state_next = RESP;
            RD:      state_next = RD_CAP;
            RD_CAP:  state_next = RESP;
            RESP:    if (resp_ready) state_next = more_beats ? RD : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr       <= '0;
            is_write   <= 1'b0;
            burst      <= 1'b0;
            beat       <= '0;
            resp_write <= 1'b0;
            resp_last  <= 1'b0;
            resp_rdata <= '0;
        end else begin
            if (accept) begin
                addr     <= req_addr;
                is_write <= req_write;
                burst    <= req_burst;
                beat     <= '0;
            end
            if (state == WR) begin
                resp_write <= 1'b1;
                resp_last  <= 1'b1;
                resp_rdata <= '0;
            end
            // RAM output register holds the word during RD_CAP
            if (state == RD_CAP) begin
                resp_rdata <= ram_data;
                resp_write <= 1'b0;
                resp_last  <= !burst || (beat == LAST_BEAT);
            end
            if (handshake && more_beats) begin
                beat <= beat + 1'b1;
                addr <= addr + 1'b1;
            end
        end
    end

    // Write word is only meaningful after an accept, so it needs no reset
    always_ff @(posedge clk) begin
        if (accept) wdata <= req_wdata;
    end

`ifdef RAM_CTRL_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_rd_beats <= '0;
            perf_wr_count <= '0;
        end else if (handshake) begin
            if (is_write) perf_wr_count <= perf_wr_count + 32'd1;
            else          perf_rd_beats <= perf_rd_beats + 32'd1;
        end
    end
`endif

    assign req_ready      = (state == IDLE);
    assign resp_valid     = (state == RESP);
    assign ram_address    = addr;
    assign ram_is_reading = (state != WR);
    assign ram_data       = ram_is_reading ? {MEM_WORD_SIZE{1'bz}} : wdata;

endmodule
